// File: rtl/csr_stream_feeder_pkg.sv
// rtl/csr_stream_feeder_pkg.sv - shared widths, sizes and FSM encodings for the CSR feeder
package csr_stream_feeder_pkg;

    localparam int DATA_BITS   = 16;
    localparam int ROW_BITS    = 7;
    localparam int COL_BITS    = 5;
    localparam int NNZ_BITS    = 10;
    localparam int WEIGHT_ROWS = 32;
    localparam int WCOL_BITS   = 3;
    localparam int WROW_BITS   = $clog2(WEIGHT_ROWS);
    // One extra bit so the word counter can sit at 2*WEIGHT_ROWS for the trailing data cycle
    localparam int WCNT_BITS   = WROW_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RP_REQ,
        S_RP_CHK,
        S_NZ_REQ,
        S_NZ_CAP,
        S_PRESENT,
        S_FINISH
    } in_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_STREAM,
        W_WAIT
    } w_state_t;

endpackage

// File: rtl/csr_stream_feeder_if.sv
// rtl/csr_stream_feeder_if.sv - element and weight streams between feeder and scheduler
interface csr_stream_feeder_if;
    import csr_stream_feeder_pkg::*;

    logic                 o_rdy;
    logic                 i_ready;
    logic [DATA_BITS-1:0] o_data;
    logic [ROW_BITS-1:0]  o_row_ptr;
    logic [COL_BITS-1:0]  o_col_idx;
    logic                 o_done;
    logic                 i_w_switch;
    logic [DATA_BITS-1:0] o_w_data;
    logic [WCOL_BITS-1:0] o_w_col_idx;
    logic                 o_w_valid;
    logic                 o_w_last_pair;

    modport master (
        output o_rdy, o_data, o_row_ptr, o_col_idx, o_done,
        output o_w_data, o_w_col_idx, o_w_valid, o_w_last_pair,
        input  i_ready, i_w_switch
    );

    modport slave (
        input  o_rdy, o_data, o_row_ptr, o_col_idx, o_done,
        input  o_w_data, o_w_col_idx, o_w_valid, o_w_last_pair,
        output i_ready, i_w_switch
    );

endinterface

// File: rtl/csr_stream_feeder_weights.sv
// rtl/csr_stream_feeder_weights.sv - weight column pair streamer (module csr_weight_streamer)
module csr_weight_streamer
    import csr_stream_feeder_pkg::*;
#(
    parameter int NUM_WCOLS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_w_switch,
    output logic [WCOL_BITS+WROW_BITS-1:0] o_w_addr,
    input  logic [DATA_BITS-1:0]           i_w_mem,
    output logic [DATA_BITS-1:0]           o_w_data,
    output logic [WCOL_BITS-1:0]           o_w_col_idx,
    output logic                           o_w_valid,
    output logic                           o_w_last_pair
);

    localparam int PAIR_BITS = WCOL_BITS - 1;
    localparam int WORDS     = 2 * WEIGHT_ROWS;
    localparam logic [PAIR_BITS-1:0] LAST_PAIR = PAIR_BITS'(NUM_WCOLS / 2 - 1);

    w_state_t               r_state, w_next;
    logic [PAIR_BITS-1:0]   r_pair;
    logic [WCNT_BITS-1:0]   r_wrow;
    logic                   r_valid;
    logic [WCOL_BITS-1:0]   r_col;
    logic                   w_issue;
    logic                   w_stream_end;
    logic [WCOL_BITS-1:0]   w_col;

    // Word counter bit 0 picks the column within the pair, upper bits give the weight row
    assign w_issue      = (r_state == W_STREAM) && (r_wrow < WCNT_BITS'(WORDS));
    assign w_stream_end = (r_state == W_STREAM) && (r_wrow == WCNT_BITS'(WORDS));
    assign w_col        = {r_pair, r_wrow[0]};

    assign o_w_addr      = w_issue ? {w_col, r_wrow[WROW_BITS:1]} : '0;
    assign o_w_data      = r_valid ? i_w_mem : '0;
    assign o_w_col_idx   = r_col;
    assign o_w_valid     = r_valid;
    assign o_w_last_pair = (r_pair == LAST_PAIR);

    always_comb begin
        w_next = r_state;
        case (r_state)
            W_IDLE:   if (i_w_switch) w_next = W_STREAM;
            W_STREAM: if (w_stream_end) w_next = W_WAIT;
            W_WAIT:   if (!i_w_switch) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= W_IDLE;
            r_pair  <= '0;
            r_wrow  <= '0;
            r_valid <= 1'b0;
            r_col   <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= w_issue;
            r_col   <= w_issue ? w_col : '0;
            if (r_state == W_IDLE && i_w_switch) begin
                r_wrow <= '0;
            end else if (w_issue) begin
                r_wrow <= r_wrow + WCNT_BITS'(1);
            end
            if (w_stream_end) begin
                r_pair <= (r_pair == LAST_PAIR) ? '0 : r_pair + PAIR_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/csr_stream_feeder.sv
// rtl/csr_stream_feeder.sv - walks a CSR matrix and streams nonzeros plus weight columns
module csr_stream_feeder
    import csr_stream_feeder_pkg::*;
#(
    parameter int NUM_ROWS  = 100,
    parameter int NUM_WCOLS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    output logic                           o_busy,
    output logic [ROW_BITS-1:0]            o_rp_addr,
    input  logic [NNZ_BITS:0]              i_rp_data,
    output logic [NNZ_BITS-1:0]            o_nz_addr,
    input  logic [DATA_BITS-1:0]           i_nz_val,
    input  logic [COL_BITS-1:0]            i_nz_col,
    output logic [WCOL_BITS+WROW_BITS-1:0] o_w_addr,
    input  logic [DATA_BITS-1:0]           i_w_mem,
    csr_stream_feeder_if.master            bus
);

    in_state_t            r_state, w_next;
    logic [ROW_BITS-1:0]  r_row;
    logic [NNZ_BITS-1:0]  r_ptr;
    logic [NNZ_BITS:0]    r_end;
    logic [DATA_BITS-1:0] r_data;
    logic [ROW_BITS-1:0]  r_row_out;
    logic [COL_BITS-1:0]  r_col;
    logic                 w_last_row;
    logic                 w_row_empty;
    logic [NNZ_BITS:0]    w_ptr_ext;
    logic [NNZ_BITS:0]    w_ptr_next;

    assign w_last_row  = (r_row == ROW_BITS'(NUM_ROWS - 1));
    assign w_ptr_ext   = {1'b0, r_ptr};
    assign w_ptr_next  = w_ptr_ext + (NNZ_BITS + 1)'(1);
    assign w_row_empty = (w_ptr_ext == i_rp_data);

    assign o_busy        = (r_state != S_IDLE);
    assign o_rp_addr     = o_busy ? r_row + ROW_BITS'(1) : '0;
    assign o_nz_addr     = r_ptr;
    assign bus.o_rdy     = (r_state == S_PRESENT);
    assign bus.o_done    = (r_state == S_FINISH);
    assign bus.o_data    = r_data;
    assign bus.o_row_ptr = r_row_out;
    assign bus.o_col_idx = r_col;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_RP_REQ;
            S_RP_REQ:  w_next = S_RP_CHK;
            S_RP_CHK:  begin
                if (w_row_empty) w_next = w_last_row ? S_FINISH : S_RP_REQ;
                else             w_next = S_NZ_REQ;
            end
            S_NZ_REQ:  w_next = S_NZ_CAP;
            S_NZ_CAP:  w_next = S_PRESENT;
            S_PRESENT: begin
                if (bus.i_ready) begin
                    if (w_ptr_next < r_end) w_next = S_NZ_REQ;
                    else                    w_next = w_last_row ? S_FINISH : S_RP_REQ;
                end
            end
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_ptr     <= '0;
            r_end     <= '0;
            r_data    <= '0;
            r_row_out <= '0;
            r_col     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row <= '0;
                        r_ptr <= '0;
                    end
                end
                S_RP_CHK: begin
                    r_end <= i_rp_data;
                    if (w_row_empty) r_row <= r_row + ROW_BITS'(1);
                end
                S_NZ_CAP: begin
                    r_data    <= i_nz_val;
                    r_col     <= i_nz_col;
                    r_row_out <= r_row;
                end
                S_PRESENT: begin
                    if (bus.i_ready) begin
                        r_ptr <= r_ptr + NNZ_BITS'(1);
                        if (!(w_ptr_next < r_end)) r_row <= r_row + ROW_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    csr_weight_streamer #(
        .NUM_WCOLS (NUM_WCOLS)
    ) u_weights (
        .clk           (clk),
        .rst           (rst),
        .i_w_switch    (bus.i_w_switch),
        .o_w_addr      (o_w_addr),
        .i_w_mem       (i_w_mem),
        .o_w_data      (bus.o_w_data),
        .o_w_col_idx   (bus.o_w_col_idx),
        .o_w_valid     (bus.o_w_valid),
        .o_w_last_pair (bus.o_w_last_pair)
    );

endmodule

// File: tb/tb_csr_stream_feeder.sv
// tb/tb_csr_stream_feeder.sv - self-checking bench for csr_stream_feeder
module tb_csr_stream_feeder;

    localparam int NR    = 3;
    localparam int NWC   = 8;
    localparam int NPAIR = NWC / 2;

    typedef struct {
        logic [15:0] val;
        int          row;
        int          col;
        int          cyc;
    } elem_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        o_busy;
    logic [6:0]  rp_addr;
    logic [10:0] rp_data;
    logic [9:0]  nz_addr;
    logic [15:0] nz_val;
    logic [4:0]  nz_col;
    logic [7:0]  w_addr;
    logic [15:0] w_mem;

    logic [10:0] rowptr_mem [0:127];
    logic [15:0] val_mem    [0:1023];
    logic [4:0]  col_mem    [0:1023];

    int    n_cmp;
    int    n_bad;
    int    w_req;
    int    done_cnt;
    int    done_cyc;
    int    rdy_cyc;
    elem_t obs_q[$];
    elem_t exp_q[$];
    elem_t dir_tab[3];

    csr_stream_feeder_if bus();

    csr_stream_feeder #(
        .NUM_ROWS  (NR),
        .NUM_WCOLS (NWC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_rp_addr (rp_addr),
        .i_rp_data (rp_data),
        .o_nz_addr (nz_addr),
        .i_nz_val  (nz_val),
        .i_nz_col  (nz_col),
        .o_w_addr  (w_addr),
        .i_w_mem   (w_mem),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rp_data <= rowptr_mem[rp_addr];
        nz_val  <= val_mem[nz_addr];
        nz_col  <= col_mem[nz_addr];
        w_mem   <= 16'(w_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(o_busy), 0);
        check({tag, "_rp_addr"},   64'(rp_addr), 0);
        check({tag, "_nz_addr"},   64'(nz_addr), 0);
        check({tag, "_rdy"},       64'(bus.o_rdy), 0);
        check({tag, "_data"},      64'(bus.o_data), 0);
        check({tag, "_row"},       64'(bus.o_row_ptr), 0);
        check({tag, "_col"},       64'(bus.o_col_idx), 0);
        check({tag, "_done"},      64'(bus.o_done), 0);
        check({tag, "_w_addr"},    64'(w_addr), 0);
        check({tag, "_w_data"},    64'(bus.o_w_data), 0);
        check({tag, "_w_col"},     64'(bus.o_w_col_idx), 0);
        check({tag, "_w_valid"},   64'(bus.o_w_valid), 0);
        check({tag, "_w_last"},    64'(bus.o_w_last_pair), 0);
    endtask

    task automatic load_directed();
        rowptr_mem[0] = 0; rowptr_mem[1] = 1; rowptr_mem[2] = 1; rowptr_mem[3] = 3;
        val_mem[0] = 16'd5; col_mem[0] = 5'd2;
        val_mem[1] = 16'd7; col_mem[1] = 5'd0;
        val_mem[2] = 16'd9; col_mem[2] = 5'd31;
    endtask

    // Expected element order straight from the CSR definition
    task automatic build_model();
        elem_t e;
        exp_q.delete();
        for (int r = 0; r < NR; r++) begin
            for (int a = int'(rowptr_mem[r]); a < int'(rowptr_mem[r+1]); a++) begin
                e.val = val_mem[a];
                e.row = r;
                e.col = int'(col_mem[a]);
                e.cyc = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // mode 0: ready always high; 1: stall the first element 4 cycles; 2: random ready and stray starts
    task automatic run_pass(input int mode);
        int          stall;
        logic        prev_hold;
        logic [15:0] pv;
        logic [6:0]  pr;
        logic [4:0]  pc;
        elem_t       e;
        obs_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        rdy_cyc   = 0;
        stall     = 4;
        prev_hold = 1'b0;
        pv = '0; pr = '0; pc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_start = (cyc == 0) || (mode == 2 && o_busy && $urandom_range(0, 4) == 0);
            if (mode == 0) begin
                bus.i_ready = 1'b1;
            end else if (mode == 1) begin
                bus.i_ready = !(bus.o_rdy && stall > 0);
                if (bus.o_rdy && stall > 0) stall--;
            end else begin
                bus.i_ready = 1'($urandom_range(0, 1));
            end
            if (prev_hold) begin
                check("hold_rdy",  64'(bus.o_rdy), 1);
                check("hold_data", 64'(bus.o_data), 64'(pv));
                check("hold_row",  64'(bus.o_row_ptr), 64'(pr));
                check("hold_col",  64'(bus.o_col_idx), 64'(pc));
            end
            if (bus.o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.o_rdy) begin
                rdy_cyc++;
                if (bus.i_ready) begin
                    e.val = bus.o_data;
                    e.row = int'(bus.o_row_ptr);
                    e.col = int'(bus.o_col_idx);
                    e.cyc = cyc;
                    obs_q.push_back(e);
                end
            end
            prev_hold = bus.o_rdy && !bus.i_ready;
            pv = bus.o_data; pr = bus.o_row_ptr; pc = bus.o_col_idx;
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
            step();
        end
        i_start = 1'b0;
        check("done_pulses", 64'(done_cnt), 1);
        check("busy_after",  64'(o_busy), 0);
    endtask

    task automatic compare_model();
        build_model();
        check("n_elems", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check("elem_val", 64'(obs_q[i].val), 64'(exp_q[i].val));
            check("elem_row", 64'(obs_q[i].row), 64'(exp_q[i].row));
            check("elem_col", 64'(obs_q[i].col), 64'(exp_q[i].col));
        end
    endtask

    // Weight word n of a request on pair p is column 2p + n%2, row n/2; memory holds {col,row}
    task automatic run_wstream(input int hold);
        int nw;
        int p;
        int col;
        int row;
        nw = 0;
        p  = w_req % NPAIR;
        for (int cyc = 0; cyc < 80; cyc++) begin
            bus.i_w_switch = (cyc < hold);
            if (bus.o_w_valid) begin
                col = 2 * p + (nw % 2);
                row = nw / 2;
                if (nw < 64) begin
                    check("w_col",  64'(bus.o_w_col_idx), 64'(col));
                    check("w_data", 64'(bus.o_w_data), 64'(col * 32 + row));
                    check("w_last_pair", 64'(bus.o_w_last_pair), 64'(p == NPAIR - 1));
                end
                nw++;
            end
            step();
        end
        bus.i_w_switch = 1'b0;
        check("w_words", 64'(nw), 64);
        w_req++;
    endtask

    task automatic randomize_matrix();
        int total;
        rowptr_mem[0] = 0;
        for (int r = 0; r < NR; r++) rowptr_mem[r+1] = rowptr_mem[r] + 11'($urandom_range(0, 3));
        total = int'(rowptr_mem[NR]);
        for (int a = 0; a < total; a++) begin
            val_mem[a] = 16'($urandom);
            col_mem[a] = 5'($urandom);
        end
    endtask

    initial begin
        int waited;
        n_cmp = 0;
        n_bad = 0;
        w_req = 0;
        for (int i = 0; i < 128; i++) rowptr_mem[i] = '0;
        for (int i = 0; i < 1024; i++) begin
            val_mem[i] = '0;
            col_mem[i] = '0;
        end
        dir_tab[0] = '{val: 16'd5, row: 0, col: 2,  cyc: 5};
        dir_tab[1] = '{val: 16'd7, row: 2, col: 0,  cyc: 12};
        dir_tab[2] = '{val: 16'd9, row: 2, col: 31, cyc: 15};

        rst = 1'b1;
        i_start = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_w_switch = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Directed matrix, ready tied high: exact values and cycles
        load_directed();
        run_pass(0);
        check("dir_count", 64'(obs_q.size()), 3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            check("dir_val", 64'(obs_q[i].val), 64'(dir_tab[i].val));
            check("dir_row", 64'(obs_q[i].row), 64'(dir_tab[i].row));
            check("dir_col", 64'(obs_q[i].col), 64'(dir_tab[i].col));
            check("dir_cyc", 64'(obs_q[i].cyc), 64'(dir_tab[i].cyc));
        end
        check("dir_done_cyc", 64'(done_cyc), 16);

        // First element stalled for 4 cycles
        run_pass(1);
        compare_model();

        // All rows empty
        for (int r = 0; r <= NR; r++) rowptr_mem[r] = '0;
        run_pass(0);
        check("empty_rdy_cycles", 64'(rdy_cyc), 0);
        check("empty_done_cyc", 64'(done_cyc), 2 * NR + 1);

        // Weight requests: pairs 0,1,2 (switch dropped mid-stream),3, then wrap to 0
        run_wstream(70);
        run_wstream(70);
        run_wstream(10);
        run_wstream(70);
        run_wstream(70);

        // Random matrices, random back-pressure, concurrent weight streams
        for (int it = 0; it < 6; it++) begin
            randomize_matrix();
            fork
                run_pass(2);
                run_wstream(int'($urandom_range(5, 75)));
            join
            compare_model();
        end

        // Reset while presenting an element and mid weight stream
        load_directed();
        bus.i_ready = 1'b0;
        bus.i_w_switch = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        waited = 0;
        while (!bus.o_rdy && waited < 20) begin
            step();
            waited++;
        end
        check("abort_reached_present", 64'(bus.o_rdy), 1);
        check("abort_w_valid", 64'(bus.o_w_valid), 1);
        rst = 1'b1;
        bus.i_w_switch = 1'b0;
        step();
        check_all_zero("abort");
        rst = 1'b0;
        w_req = 0;
        step();
        run_pass(0);
        check("restart_count", 64'(obs_q.size()), 3);
        if (obs_q.size() > 0) begin
            check("restart_val", 64'(obs_q[0].val), 64'(dir_tab[0].val));
            check("restart_row", 64'(obs_q[0].row), 64'(dir_tab[0].row));
            check("restart_cyc", 64'(obs_q[0].cyc), 64'(dir_tab[0].cyc));
        end
        run_wstream(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
